// File: rtl/cnt_ctrl_pkg.sv
// Shared run-state type, button event bundle and default timing constants
// for the mod-60 counter control front-end.
package cnt_ctrl_pkg;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    typedef struct packed {
        logic ss;
        logic inc;
        logic clr;
    } btn_evt_t;

    localparam int DIV_DEF     = 50_000_000;
    localparam int DEB_CYC_DEF = 500_000;
    localparam int REP_DLY_DEF = 25_000_000;
    localparam int REP_PER_DEF = 5_000_000;

    // Bits needed for a counter that runs 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnt_tick_ctrl_if.sv
// Raw button inputs and control outputs of cnt_tick_ctrl; master is the
// board/stimulus side, slave is the controller.
interface cnt_tick_ctrl_if;

    logic btn_ss_raw;
    logic btn_inc_raw;
    logic btn_clr_raw;
    logic CEN;
    logic INC;
    logic CLR;
    logic running;

    modport master (
        output btn_ss_raw, btn_inc_raw, btn_clr_raw,
        input  CEN, INC, CLR, running
    );

    modport slave (
        input  btn_ss_raw, btn_inc_raw, btn_clr_raw,
        output CEN, INC, CLR, running
    );

endinterface

// File: rtl/btn_debounce.sv
// One push button: 2-FF synchronizer, run-length debounce of the accepted
// level, and a one-cycle press pulse on its rising edge.
module btn_debounce #(
    parameter int DEB_CYC = 500_000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q      <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync_q      <= {sync_q[0], raw};
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    // NOTE: defaults at the top of always_comb keep every path assigned, so no latch is inferred.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign press = level_q & ~level_dly_q;

endmodule

// File: rtl/cnt_tick_ctrl.sv
// Control front-end for the mod-60 counter: CEN prescaler, debounced
// start/stop, increment and clear buttons, STOP/RUN state.
// Optional INC auto-repeat is built when AUTO_REPEAT_EN is defined.
module cnt_tick_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int DIV     = DIV_DEF,
    parameter int DEB_CYC = DEB_CYC_DEF,
    parameter int REP_DLY = REP_DLY_DEF,
    parameter int REP_PER = REP_PER_DEF
) (
    input  logic           clk,
    input  logic           n_rst,
    cnt_tick_ctrl_if.slave bus
);

    localparam int PW = cnt_width(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    btn_evt_t   press;
    btn_evt_t   level;
    logic       unused_levels;

    run_state_t state_q, state_d;
    logic       running_q, running_d;
    logic       cen_q, cen_d;
    logic       inc_q, inc_d;
    logic       clr_q, clr_d;
    logic [PW-1:0] pre_q, pre_d;
    logic       rep_fire;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_ss (
        .clk   (clk),
        .n_rst (n_rst),
        .raw   (bus.btn_ss_raw),
        .level (level.ss),
        .press (press.ss)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
        .clk   (clk),
        .n_rst (n_rst),
        .raw   (bus.btn_inc_raw),
        .level (level.inc),
        .press (press.inc)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_clr (
        .clk   (clk),
        .n_rst (n_rst),
        .raw   (bus.btn_clr_raw),
        .level (level.clr),
        .press (press.clr)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (press.ss) begin
            state_d = (state_q == ST_STOP) ? ST_RUN : ST_STOP;
        end
    end

    // Clear wins over increment; CEN and INC are exclusive because they key off opposite states.
    always_comb begin
        running_d = (state_q == ST_RUN);
        clr_d     = press.clr;
        cen_d     = (state_q == ST_RUN) && (pre_q == PRE_LAST) && !press.clr;
        inc_d     = (state_q == ST_STOP) && !press.clr && (press.inc || rep_fire);
    end

    always_comb begin
        pre_d = pre_q;
        if ((state_q != ST_RUN) || press.clr) begin
            pre_d = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            running_q <= 1'b0;
            cen_q     <= 1'b0;
            inc_q     <= 1'b0;
            clr_q     <= 1'b0;
            pre_q     <= '0;
        end else begin
            running_q <= running_d;
            cen_q     <= cen_d;
            inc_q     <= inc_d;
            clr_q     <= clr_d;
            pre_q     <= pre_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int RW = cnt_width(REP_MAX);
    localparam logic [RW-1:0] DLY_LAST = RW'(REP_DLY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REP_PER - 1);

    logic          rep_act_q;
    logic          rep_first_q;
    logic [RW-1:0] rep_cnt_q;
    logic          rep_start, rep_keep, rep_hit;

    // The timer is armed only by an INC that actually went out.
    always_comb begin
        rep_start = press.inc && (state_q == ST_STOP) && !press.clr;
        rep_keep  = rep_act_q && level.inc && (state_q == ST_STOP) && !press.clr;
        rep_hit   = rep_first_q ? (rep_cnt_q == DLY_LAST) : (rep_cnt_q == PER_LAST);
        rep_fire  = rep_keep && rep_hit;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rep_act_q   <= 1'b0;
            rep_first_q <= 1'b0;
            rep_cnt_q   <= '0;
        end else if (rep_start) begin
            rep_act_q   <= 1'b1;
            rep_first_q <= 1'b1;
            rep_cnt_q   <= '0;
        end else if (!rep_keep) begin
            rep_act_q   <= 1'b0;
        end else if (rep_hit) begin
            rep_first_q <= 1'b0;
            rep_cnt_q   <= '0;
        end else begin
            rep_cnt_q   <= rep_cnt_q + 1'b1;
        end
    end

    assign unused_levels = level.ss ^ level.clr;
`else
    assign rep_fire      = 1'b0;
    assign unused_levels = ^level;

    // Repeat timing is accepted for drop-in compatibility but builds no logic here.
    if ((REP_DLY < 1) || (REP_PER < 1)) begin : g_rep_cfg_ignored
    end
`endif

    assign bus.CEN     = cen_q;
    assign bus.INC     = inc_q;
    assign bus.CLR     = clr_q;
    assign bus.running = running_q;

endmodule
